// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_RUN   = 2'd1,
        FS_DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; DEPTH must be a power of two.
// A push on a full queue is accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == (AW+1)'(DEPTH));
        do_pop  = pop && !empty && !flush;
        do_push = push && (!full || do_pop) && !flush;

        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: credit-limited requests, in-order responses,
// redirect flush with in-flight drain. Optional same-cycle bypass: FETCH_BYPASS_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_resp_valid,
    input  logic [DATA_WIDTH-1:0] imem_resp_data,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic [ADDR_WIDTH-1:0] pcplus4
);

    localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned OW        = DATA_WIDTH + ADDR_WIDTH;
    localparam logic [CW:0] DEPTH_LIM = (CW+1)'(FIFO_DEPTH);

`ifdef FETCH_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]         inflight_q, inflight_d;
    logic [CW-1:0]         drop_cnt_q, drop_cnt_d;

    logic                  rq_push, rq_pop, rq_full, rq_empty;
    logic [CW-1:0]         rq_count;
    logic [ADDR_WIDTH-1:0] rq_head;

    logic                  oq_push, oq_pop, oq_flush, oq_full, oq_empty;
    logic [CW-1:0]         oq_count;
    logic [OW-1:0]         oq_head, oq_wdata;

    logic                  resp, accept, credit, bypass;
    logic [ADDR_WIDTH-1:0] head_pc;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  unused_ok;

    sync_fifo #(.WIDTH(ADDR_WIDTH), .DEPTH(FIFO_DEPTH)) u_req_q (
        .clk(clk), .rst(rst), .flush(1'b0),
        .push(rq_push), .push_data(fetch_pc_q),
        .pop(rq_pop), .pop_data(rq_head),
        .full(rq_full), .empty(rq_empty), .count(rq_count)
    );

    sync_fifo #(.WIDTH(OW), .DEPTH(FIFO_DEPTH)) u_out_q (
        .clk(clk), .rst(rst), .flush(oq_flush),
        .push(oq_push), .push_data(oq_wdata),
        .pop(oq_pop), .pop_data(oq_head),
        .full(oq_full), .empty(oq_empty), .count(oq_count)
    );

    always_comb begin
        resp   = imem_resp_valid && (inflight_q != '0);
        credit = ({1'b0, inflight_q} + {1'b0, oq_count}) < DEPTH_LIM;
        bypass = BYPASS && (state_q == FS_RUN) && !redirect_valid && resp && oq_empty;

        state_d        = state_q;
        fetch_pc_d     = fetch_pc_q;
        drop_cnt_d     = drop_cnt_q;
        imem_req_valid = 1'b0;
        oq_push        = 1'b0;
        oq_flush       = 1'b0;
        rq_pop         = resp;
        oq_wdata       = {rq_head, imem_resp_data};
        oq_pop         = !oq_empty && instr_ready && !redirect_valid;

        case (state_q)
            FS_IDLE: state_d = FS_RUN;
            FS_RUN, FS_DRAIN: begin
                // Every outstanding response, including one arriving now, is dropped.
                if (redirect_valid) begin
                    oq_flush   = 1'b1;
                    fetch_pc_d = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
                    drop_cnt_d = inflight_q - CW'(resp);
                    state_d    = (drop_cnt_d != '0) ? FS_DRAIN : FS_RUN;
                end else if (state_q == FS_RUN) begin
                    imem_req_valid = credit;
                    oq_push        = resp && !(bypass && instr_ready);
                end else if (resp) begin
                    drop_cnt_d = drop_cnt_q - CW'(1);
                    if (drop_cnt_q == CW'(1)) begin
                        state_d = FS_RUN;
                    end
                end
            end
            default: state_d = FS_IDLE;
        endcase

        accept  = imem_req_valid && imem_req_ready;
        rq_push = accept;
        if (accept) begin
            fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(PC_STEP);
        end
        inflight_d = inflight_q + CW'(accept) - CW'(resp);
    end

    always_comb begin
        head_pc     = oq_head[OW-1:DATA_WIDTH];
        head_data   = oq_head[DATA_WIDTH-1:0];
        instr_valid = !oq_empty;
        if (bypass) begin
            head_pc     = rq_head;
            head_data   = imem_resp_data;
            instr_valid = 1'b1;
        end
        instr    = instr_valid ? head_data : DATA_WIDTH'(INSTR_NOP);
        instr_pc = instr_valid ? head_pc : '0;
        pcplus4  = instr_valid ? head_pc + ADDR_WIDTH'(PC_STEP) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FS_IDLE;
            fetch_pc_q <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign imem_req_addr = fetch_pc_q;
    assign unused_ok     = ^{rq_full, rq_empty, rq_count, oq_full, redirect_pc[1:0]};

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit against a transaction-level model.
module tb_fetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct { logic [31:0] addr; int due; } mem_ent_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid, imem_req_valid, imem_req_ready, imem_resp_valid;
    logic        instr_valid, instr_ready;
    logic [31:0] redirect_pc, imem_req_addr, imem_resp_data, instr, instr_pc, pcplus4;

    logic        d2_req_valid, d2_resp_valid, d2_instr_valid;
    logic [31:0] d2_req_addr, d2_resp_data, d2_instr, d2_instr_pc, d2_pcplus4;
    logic        d2_one  = 1'b1;
    logic        d2_zero = 1'b0;
    logic [31:0] d2_zpc  = 32'h0;

    fetch_unit u_dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .pcplus4(pcplus4)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut_hi (
        .clk(clk), .rst(rst),
        .redirect_valid(d2_zero), .redirect_pc(d2_zpc),
        .imem_req_valid(d2_req_valid), .imem_req_ready(d2_one),
        .imem_req_addr(d2_req_addr),
        .imem_resp_valid(d2_resp_valid), .imem_resp_data(d2_resp_data),
        .instr_valid(d2_instr_valid), .instr_ready(d2_one),
        .instr(d2_instr), .instr_pc(d2_instr_pc), .pcplus4(d2_pcplus4)
    );

    always #5 clk = ~clk;

    // Always-ready single-cycle memory for the high-RESET_PC instance.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            d2_resp_valid <= 1'b0;
            d2_resp_data  <= 32'h0;
        end else begin
            d2_resp_valid <= d2_req_valid;
            d2_resp_data  <= d2_req_addr ^ 32'h1111_1111;
        end
    end

    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    int          win = 0;
    int          first_valid_win = 0;
    int          mem_lat = 1;
    logic [31:0] m_pc;
    int          m_drop;
    bit          m_idle;
    mem_ent_t    mem_q[$];
    exp_ent_t    exp_q[$];
    logic [31:0] acc_q[$];
    logic [31:0] deliv_q[$];
    logic [31:0] acc2_q[$];
    bit          p4_seen;
    logic [31:0] p4_val;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic do_reset();
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        imem_req_ready  = 1'b0;
        instr_ready     = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        mem_q.delete(); exp_q.delete(); acc_q.delete(); deliv_q.delete(); acc2_q.delete();
        m_pc = 32'h0; m_drop = 0; m_idle = 1'b1; p4_seen = 1'b0; p4_val = 32'hX;
        win = 0; first_valid_win = 0;
        #2 rst = 1'b0;
    endtask

    // One clock: drive at negedge, compare against the model, advance the model at posedge.
    task automatic cycle(input bit redir, input logic [31:0] tgt, input bit rdy, input bit ir);
        bit       resp, exp_req, acc, pop;
        mem_ent_t r;
        exp_ent_t e;
        @(negedge clk);
        win++;
        if (m_idle) redir = 1'b0;
        redirect_valid  = redir;
        redirect_pc     = tgt;
        imem_req_ready  = rdy;
        instr_ready     = ir;
        resp            = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_resp_valid = resp;
        imem_resp_data  = resp ? mem_word(mem_q[0].addr) : $urandom();
        #1;
        exp_req = !m_idle && (m_drop == 0) && !redir && (mem_q.size() + exp_q.size() < DEPTH);
        n_total++;
        if (imem_req_valid !== exp_req)
            $display("FAIL req_valid win=%0d got=%b exp=%b", win, imem_req_valid, exp_req);
        else n_pass++;
        if (exp_req) begin
            n_total++;
            if (imem_req_addr !== m_pc)
                $display("FAIL req_addr win=%0d got=%h exp=%h", win, imem_req_addr, m_pc);
            else n_pass++;
        end
        n_total++;
        if (instr_valid !== (exp_q.size() > 0))
            $display("FAIL instr_valid win=%0d got=%b exp=%b", win, instr_valid, exp_q.size() > 0);
        else n_pass++;
        if (exp_q.size() > 0) begin
            e = exp_q[0];
            n_total++;
            if (instr !== e.data || instr_pc !== e.pc || pcplus4 !== e.pc + 32'd4)
                $display("FAIL instr_head win=%0d got=%h/%h/%h exp=%h/%h/%h",
                         win, instr, instr_pc, pcplus4, e.data, e.pc, e.pc + 32'd4);
            else n_pass++;
            if (first_valid_win == 0) first_valid_win = win;
        end else begin
            n_total++;
            if (instr !== NOP || instr_pc !== 32'h0 || pcplus4 !== 32'h0)
                $display("FAIL idle_outputs win=%0d got=%h/%h/%h exp=%h/0/0",
                         win, instr, instr_pc, pcplus4, NOP);
            else n_pass++;
        end
        if (d2_req_valid) acc2_q.push_back(d2_req_addr);
        if (d2_instr_valid && d2_instr_pc == 32'hFFFF_FFFC) begin
            p4_seen = 1'b1;
            p4_val  = d2_pcplus4;
        end
        acc = exp_req && rdy;
        pop = (exp_q.size() > 0) && ir && !redir;
        if (imem_req_valid && rdy) acc_q.push_back(imem_req_addr);
        if (pop) deliv_q.push_back(instr_pc);
        @(posedge clk);
        cyc++;
        if (resp) r = mem_q.pop_front();
        if (m_idle) begin
            m_idle = 1'b0;
        end else if (redir) begin
            exp_q.delete();
            m_pc   = {tgt[31:2], 2'b00};
            m_drop = mem_q.size();
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (resp) begin
                if (m_drop > 0) m_drop--;
                else exp_q.push_back('{pc: r.addr, data: mem_word(r.addr)});
            end
            if (acc) begin
                mem_q.push_back('{addr: m_pc, due: cyc - 1 + mem_lat});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_total++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || instr !== NOP ||
            instr_pc !== 32'h0 || pcplus4 !== 32'h0)
            $display("FAIL reset_outputs got=%b/%b/%h/%h/%h exp=0/0/%h/0/0",
                     imem_req_valid, instr_valid, instr, instr_pc, pcplus4, NOP);
        else n_pass++;
        do_reset();
        mem_lat = 1;
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
    endtask

    task automatic test_stream();
        bit ok;
        do_reset();
        mem_lat = 1;
        repeat (20) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        n_total++;
        if (first_valid_win !== 4)
            $display("FAIL first_valid_window got=%0d exp=4", first_valid_win);
        else n_pass++;
        n_total++;
        if (deliv_q.size() !== 17)
            $display("FAIL stream_throughput got=%0d exp=17", deliv_q.size());
        else n_pass++;
        ok = 1'b1;
        foreach (deliv_q[i]) if (deliv_q[i] !== 32'(4 * i)) ok = 1'b0;
        n_total++;
        if (!ok) $display("FAIL stream_order got=%b exp=1", ok);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset();
        mem_lat = 1;
        repeat (12) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        n_total++;
        if (acc_q.size() !== DEPTH)
            $display("FAIL bp_accepts got=%0d exp=%0d", acc_q.size(), DEPTH);
        else n_pass++;
        repeat (12) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        ok = (deliv_q.size() >= 4);
        if (ok) for (int i = 0; i < 4; i++) if (deliv_q[i] !== 32'(4 * i)) ok = 1'b0;
        n_total++;
        if (!ok) $display("FAIL bp_drain_order got=%b exp=1", ok);
        else n_pass++;
        n_total++;
        if (acc_q.size() <= DEPTH)
            $display("FAIL bp_resume got=%0d exp>%0d", acc_q.size(), DEPTH);
        else n_pass++;
    endtask

    task automatic test_redirect_drain();
        int  d0, a0;
        bit  fired;
        do_reset();
        mem_lat = 3;
        fired = 1'b0;
        d0 = 0; a0 = 0;
        for (int i = 0; i < 20 && !fired; i++) begin
            if (!m_idle && mem_q.size() == 2 && mem_q[0].due > cyc) begin
                d0 = deliv_q.size();
                a0 = acc_q.size();
                cycle(1'b1, 32'h100, 1'b1, 1'b1);
                fired = 1'b1;
            end else cycle(1'b0, 32'h0, 1'b1, 1'b1);
        end
        n_total++;
        if (!fired || m_drop != 2)
            $display("FAIL drain_setup got=%0d exp=2", m_drop);
        else n_pass++;
        for (int i = 0; i < 30 && deliv_q.size() == d0; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        n_total++;
        if (acc_q.size() <= a0 || acc_q[a0] !== 32'h100)
            $display("FAIL drain_next_req got=%h exp=00000100",
                     acc_q.size() > a0 ? acc_q[a0] : 32'hX);
        else n_pass++;
        n_total++;
        if (deliv_q.size() <= d0 || deliv_q[d0] !== 32'h100)
            $display("FAIL drain_first_instr got=%h exp=00000100",
                     deliv_q.size() > d0 ? deliv_q[d0] : 32'hX);
        else n_pass++;
    endtask

    task automatic test_redirect_collide();
        int a0;
        bit fired;
        do_reset();
        mem_lat = 1;
        repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        fired = 1'b0;
        a0 = 0;
        for (int i = 0; i < 20 && !fired; i++) begin
            if (mem_q.size() > 0 && mem_q[0].due <= cyc && exp_q.size() > 0) begin
                a0 = acc_q.size();
                cycle(1'b1, 32'h203, 1'b1, 1'b1);
                fired = 1'b1;
            end else cycle(1'b0, 32'h0, 1'b1, 1'b1);
        end
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        n_total++;
        if (!fired || acc_q.size() <= a0 || acc_q[a0] !== 32'h200)
            $display("FAIL collide_next_req got=%h exp=00000200",
                     acc_q.size() > a0 ? acc_q[a0] : 32'hX);
        else n_pass++;
        repeat (8) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    endtask

    task automatic test_wrap();
        logic [31:0] exp_a [3];
        logic [31:0] got;
        exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0;
        do_reset();
        mem_lat = 1;
        repeat (12) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            got = (acc2_q.size() > i) ? acc2_q[i] : 32'hX;
            n_total++;
            if (got !== exp_a[i])
                $display("FAIL resetpc_addr%0d got=%h exp=%h", i, got, exp_a[i]);
            else n_pass++;
        end
        n_total++;
        if (p4_seen !== 1'b1 || p4_val !== 32'h0)
            $display("FAIL resetpc_pcplus4 got=%b/%h exp=1/00000000", p4_seen, p4_val);
        else n_pass++;
        cycle(1'b1, 32'hFFFF_FFFA, 1'b1, 1'b1);
        repeat (10) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if (i % 250 == 0) mem_lat = $urandom_range(1, 4);
            cycle(($urandom_range(0, 99) < 3), $urandom(),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
        end
    endtask

    task automatic test_reset_midstream();
        bit fired;
        do_reset();
        mem_lat = 4;
        repeat (4) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        fired = 1'b0;
        for (int i = 0; i < 20 && !fired; i++) begin
            if (mem_q.size() >= 2) begin
                cycle(1'b1, 32'h40, 1'b1, 1'b1);
                fired = 1'b1;
            end else cycle(1'b0, 32'h0, 1'b1, 1'b1);
        end
        redirect_valid = 1'b0;
        imem_resp_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        n_total++;
        if (!fired || m_drop == 0 || imem_req_valid !== 1'b0 || instr_valid !== 1'b0 ||
            instr !== NOP || instr_pc !== 32'h0 || pcplus4 !== 32'h0)
            $display("FAIL async_reset got=%0d/%b/%b/%h/%h/%h exp=>0/0/0/%h/0/0",
                     m_drop, imem_req_valid, instr_valid, instr, instr_pc, pcplus4, NOP);
        else n_pass++;
        do_reset();
        mem_lat = 2;
        repeat (15) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        n_total++;
        if (acc_q.size() == 0 || acc_q[0] !== 32'h0 || deliv_q.size() == 0 || deliv_q[0] !== 32'h0)
            $display("FAIL restart_pc got=%h/%h exp=0/0",
                     acc_q.size() > 0 ? acc_q[0] : 32'hX, deliv_q.size() > 0 ? deliv_q[0] : 32'hX);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drain();
        test_redirect_collide();
        test_wrap();
        test_random();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
